// File: rtl/decode_pkg.sv
// Shared encodings for the decode_buffer stage: RV opcodes, format classes and
// shift-immediate funct7 patterns, plus the shift-encoding legality helper.
package decode_pkg;

    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_OP     = 7'b0110011;
    localparam logic [6:0] OP_SYSTEM = 7'b1110011;
    localparam logic [6:0] OP_FENCE  = 7'b0001111;

    localparam logic [2:0] F3_SLL = 3'b001;
    localparam logic [2:0] F3_SR  = 3'b101;

    localparam logic [6:0] F7_SHIFT_LOGIC = 7'b0000000;
    localparam logic [6:0] F7_SHIFT_ARITH = 7'b0100000;

    typedef enum logic [2:0] {
        FMT_R   = 3'd0,
        FMT_I   = 3'd1,
        FMT_S   = 3'd2,
        FMT_B   = 3'd3,
        FMT_U   = 3'd4,
        FMT_J   = 3'd5,
        FMT_SYS = 3'd6
    } fmt_e;

    // On RV64 bit 25 belongs to the shamt, so it is masked out of the funct7 check.
    function automatic logic shift_ok(input logic [31:0] instr, input logic rv64);
        logic [6:0] upper;
        upper = instr[31:25];
        if (rv64) begin
            upper[0] = 1'b0;
        end else begin
            upper[0] = instr[25];
        end
        if (upper == F7_SHIFT_LOGIC) begin
            return 1'b1;
        end else if ((instr[14:12] == F3_SR) && (upper == F7_SHIFT_ARITH)) begin
            return 1'b1;
        end else begin
            return 1'b0;
        end
    endfunction

endpackage

// File: rtl/decode_buffer_if.sv
// Fetch-side and execute-side handshake bundle of the decode_buffer stage.
interface decode_buffer_if #(
    parameter int XLEN = 32,
    parameter int PC_W = 32
);
    logic            in_valid;
    logic            in_ready;
    logic [31:0]     in_instr;
    logic [PC_W-1:0] in_pc;
    logic            out_valid;
    logic            out_ready;
    logic [PC_W-1:0] out_pc;
    logic [4:0]      out_rs1;
    logic [4:0]      out_rs2;
    logic [4:0]      out_rd;
    logic [XLEN-1:0] out_imm;
    logic [2:0]      out_fmt;
    logic            out_uses_rs1;
    logic            out_uses_rs2;
    logic            out_writes_rd;
    logic            out_illegal;

    modport master (
        output in_valid, in_instr, in_pc, out_ready,
        input  in_ready, out_valid, out_pc, out_rs1, out_rs2, out_rd, out_imm,
               out_fmt, out_uses_rs1, out_uses_rs2, out_writes_rd, out_illegal
    );

    modport slave (
        input  in_valid, in_instr, in_pc, out_ready,
        output in_ready, out_valid, out_pc, out_rs1, out_rs2, out_rd, out_imm,
               out_fmt, out_uses_rs1, out_uses_rs2, out_writes_rd, out_illegal
    );
endinterface

// File: rtl/decode_fifo.sv
// DEPTH-entry storage of {pc, instr} words with occupancy count; flush empties it.
module decode_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 64
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     flush,
    input  logic                     push,
    input  logic                     pop,
    input  logic [WIDTH-1:0]         wdata,
    output logic [WIDTH-1:0]         rdata,
    output logic [$clog2(DEPTH):0]   count
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_CNT = (AW + 1)'(DEPTH);

    logic [WIDTH-1:0] mem_r [DEPTH];
    logic [AW-1:0]    wr_ptr_r;
    logic [AW-1:0]    rd_ptr_r;
    logic [AW:0]      count_r;
    logic             do_push_s;
    logic             do_pop_s;

    assign do_push_s = push && (count_r < FULL_CNT);
    assign do_pop_s  = pop && (count_r != {(AW + 1){1'b0}});
    assign rdata     = mem_r[rd_ptr_r];
    assign count     = count_r;

    // Pointer and occupancy bookkeeping; pointers wrap naturally at DEPTH.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_r <= {AW{1'b0}};
            rd_ptr_r <= {AW{1'b0}};
            count_r  <= {(AW + 1){1'b0}};
        end else if (flush) begin
            wr_ptr_r <= {AW{1'b0}};
            rd_ptr_r <= {AW{1'b0}};
            count_r  <= {(AW + 1){1'b0}};
        end else begin
            if (do_push_s) begin
                wr_ptr_r <= wr_ptr_r + {{(AW - 1){1'b0}}, 1'b1};
            end
            if (do_pop_s) begin
                rd_ptr_r <= rd_ptr_r + {{(AW - 1){1'b0}}, 1'b1};
            end
            count_r <= count_r + (AW + 1)'(do_push_s) - (AW + 1)'(do_pop_s);
        end
    end

    // Entry storage; contents are only meaningful below count so it needs no reset.
    always_ff @(posedge clk) begin
        if (do_push_s && !flush) begin
            mem_r[wr_ptr_r] <= wdata;
        end
    end

endmodule

// File: rtl/decode_buffer.sv
// Buffered decode stage: FIFO of fetched {pc, instr}, combinational RV decode of
// the head, and a registered output stage toward execute.
module decode_buffer
    import decode_pkg::*;
#(
    parameter int XLEN  = 32,
    parameter int DEPTH = 4,
    parameter int PC_W  = 32
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           flush,
    decode_buffer_if.slave bus
);
    localparam int CW = $clog2(DEPTH) + 1;
    localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

    logic [CW-1:0]      count_s;
    logic [PC_W+31:0]   head_s;
    logic [PC_W-1:0]    head_pc_s;
    logic [31:0]        head_instr_s;
    logic               push_s;
    logic               pop_s;
    logic               in_ready_s;

    fmt_e               fmt_s;
    logic [31:0]        imm32_s;
    logic               is_shamt_s;
    logic               illegal_s;
    logic               uses_rs1_s;
    logic               uses_rs2_s;
    logic               has_rd_s;
    logic [XLEN-1:0]    imm_s;
    logic [2:0]         fmt_out_s;
    logic               uses_rs1_out_s;
    logic               uses_rs2_out_s;
    logic               writes_rd_out_s;

    logic               out_valid_r;
    logic [PC_W-1:0]    out_pc_r;
    logic [4:0]         out_rs1_r;
    logic [4:0]         out_rs2_r;
    logic [4:0]         out_rd_r;
    logic [XLEN-1:0]    out_imm_r;
    logic [2:0]         out_fmt_r;
    logic               out_uses_rs1_r;
    logic               out_uses_rs2_r;
    logic               out_writes_rd_r;
    logic               out_illegal_r;

    // in_ready deliberately ignores out_ready: a full FIFO refuses even while popping.
    assign in_ready_s   = (count_s < FULL_CNT);
    assign push_s       = bus.in_valid && in_ready_s;
    assign pop_s        = (count_s != {CW{1'b0}}) && (!out_valid_r || bus.out_ready);
    assign head_pc_s    = head_s[PC_W+31:32];
    assign head_instr_s = head_s[31:0];

    decode_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (PC_W + 32)
    ) u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .flush (flush),
        .push  (push_s),
        .pop   (pop_s),
        .wdata ({bus.in_pc, bus.in_instr}),
        .rdata (head_s),
        .count (count_s)
    );

    // Opcode classification and raw 32-bit immediate of the FIFO head.
    always_comb begin
        fmt_s      = FMT_R;
        imm32_s    = 32'd0;
        is_shamt_s = 1'b0;
        illegal_s  = 1'b0;
        uses_rs1_s = 1'b0;
        uses_rs2_s = 1'b0;
        has_rd_s   = 1'b0;
        if (head_instr_s[1:0] != 2'b11) begin
            illegal_s = 1'b1;
        end else begin
            case (head_instr_s[6:0])
                OP_LUI, OP_AUIPC: begin
                    fmt_s    = FMT_U;
                    imm32_s  = {head_instr_s[31:12], 12'h000};
                    has_rd_s = 1'b1;
                end
                OP_JAL: begin
                    fmt_s    = FMT_J;
                    imm32_s  = {{12{head_instr_s[31]}}, head_instr_s[19:12], head_instr_s[20],
                                head_instr_s[30:21], 1'b0};
                    has_rd_s = 1'b1;
                end
                OP_JALR, OP_LOAD: begin
                    fmt_s      = FMT_I;
                    imm32_s    = {{20{head_instr_s[31]}}, head_instr_s[31:20]};
                    uses_rs1_s = 1'b1;
                    has_rd_s   = 1'b1;
                end
                OP_IMM: begin
                    fmt_s      = FMT_I;
                    uses_rs1_s = 1'b1;
                    has_rd_s   = 1'b1;
                    if ((head_instr_s[14:12] == F3_SLL) || (head_instr_s[14:12] == F3_SR)) begin
                        is_shamt_s = 1'b1;
                        illegal_s  = !shift_ok(head_instr_s, (XLEN == 64));
                    end else begin
                        imm32_s = {{20{head_instr_s[31]}}, head_instr_s[31:20]};
                    end
                end
                OP_STORE: begin
                    fmt_s      = FMT_S;
                    imm32_s    = {{20{head_instr_s[31]}}, head_instr_s[31:25], head_instr_s[11:7]};
                    uses_rs1_s = 1'b1;
                    uses_rs2_s = 1'b1;
                end
                OP_BRANCH: begin
                    fmt_s      = FMT_B;
                    imm32_s    = {{20{head_instr_s[31]}}, head_instr_s[7], head_instr_s[30:25],
                                  head_instr_s[11:8], 1'b0};
                    uses_rs1_s = 1'b1;
                    uses_rs2_s = 1'b1;
                end
                OP_OP: begin
                    fmt_s      = FMT_R;
                    uses_rs1_s = 1'b1;
                    uses_rs2_s = 1'b1;
                    has_rd_s   = 1'b1;
                end
                OP_SYSTEM, OP_FENCE: begin
                    fmt_s = FMT_SYS;
                end
                default: begin
                    illegal_s = 1'b1;
                end
            endcase
        end
    end

    // Final XLEN immediate and flags; an illegal instruction carries no decode info.
    always_comb begin
        imm_s           = {XLEN{1'b0}};
        fmt_out_s       = 3'd0;
        uses_rs1_out_s  = 1'b0;
        uses_rs2_out_s  = 1'b0;
        writes_rd_out_s = 1'b0;
        if (illegal_s) begin
            imm_s = {XLEN{1'b0}};
        end else begin
            fmt_out_s       = fmt_s;
            uses_rs1_out_s  = uses_rs1_s;
            uses_rs2_out_s  = uses_rs2_s;
            writes_rd_out_s = has_rd_s && (head_instr_s[11:7] != 5'd0);
            if (is_shamt_s) begin
                imm_s = (XLEN == 64) ? XLEN'(head_instr_s[25:20]) : XLEN'(head_instr_s[24:20]);
            end else begin
                imm_s = XLEN'($signed(imm32_s));
            end
        end
    end

    // Output stage: loads on pop, holds under backpressure, cleared by flush.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid_r     <= 1'b0;
            out_pc_r        <= {PC_W{1'b0}};
            out_rs1_r       <= 5'd0;
            out_rs2_r       <= 5'd0;
            out_rd_r        <= 5'd0;
            out_imm_r       <= {XLEN{1'b0}};
            out_fmt_r       <= 3'd0;
            out_uses_rs1_r  <= 1'b0;
            out_uses_rs2_r  <= 1'b0;
            out_writes_rd_r <= 1'b0;
            out_illegal_r   <= 1'b0;
        end else if (flush) begin
            out_valid_r     <= 1'b0;
            out_pc_r        <= {PC_W{1'b0}};
            out_rs1_r       <= 5'd0;
            out_rs2_r       <= 5'd0;
            out_rd_r        <= 5'd0;
            out_imm_r       <= {XLEN{1'b0}};
            out_fmt_r       <= 3'd0;
            out_uses_rs1_r  <= 1'b0;
            out_uses_rs2_r  <= 1'b0;
            out_writes_rd_r <= 1'b0;
            out_illegal_r   <= 1'b0;
        end else if (pop_s) begin
            out_valid_r     <= 1'b1;
            out_pc_r        <= head_pc_s;
            out_rs1_r       <= head_instr_s[19:15];
            out_rs2_r       <= head_instr_s[24:20];
            out_rd_r        <= head_instr_s[11:7];
            out_imm_r       <= imm_s;
            out_fmt_r       <= fmt_out_s;
            out_uses_rs1_r  <= uses_rs1_out_s;
            out_uses_rs2_r  <= uses_rs2_out_s;
            out_writes_rd_r <= writes_rd_out_s;
            out_illegal_r   <= illegal_s;
        end else if (bus.out_ready) begin
            out_valid_r <= 1'b0;
        end
    end

    assign bus.in_ready      = in_ready_s;
    assign bus.out_valid     = out_valid_r;
    assign bus.out_pc        = out_pc_r;
    assign bus.out_rs1       = out_rs1_r;
    assign bus.out_rs2       = out_rs2_r;
    assign bus.out_rd        = out_rd_r;
    assign bus.out_imm       = out_imm_r;
    assign bus.out_fmt       = out_fmt_r;
    assign bus.out_uses_rs1  = out_uses_rs1_r;
    assign bus.out_uses_rs2  = out_uses_rs2_r;
    assign bus.out_writes_rd = out_writes_rd_r;
    assign bus.out_illegal   = out_illegal_r;

endmodule

// File: tb/tb_decode_buffer.sv
// Directed scoreboard bench for decode_buffer: an XLEN=32 and an XLEN=64 instance.
module tb_decode_buffer;

    typedef struct packed {
        logic [31:0] pc;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [4:0]  rd;
        logic [63:0] imm;
        logic [2:0]  fmt;
        logic        u1;
        logic        u2;
        logic        wr;
        logic        ill;
    } exp_t;

    logic clk;
    logic rst_n;
    logic flush32;
    logic flush64;
    int   checks;
    int   failures;
    exp_t sb32[$];
    exp_t sb64[$];
    exp_t e32;
    exp_t e64;

    decode_buffer_if #(.XLEN(32), .PC_W(32)) b32 ();
    decode_buffer_if #(.XLEN(64), .PC_W(32)) b64 ();

    decode_buffer #(.XLEN(32), .DEPTH(4), .PC_W(32)) dut32 (
        .clk(clk), .rst_n(rst_n), .flush(flush32), .bus(b32));
    decode_buffer #(.XLEN(64), .DEPTH(4), .PC_W(32)) dut64 (
        .clk(clk), .rst_n(rst_n), .flush(flush64), .bus(b64));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic exp_t mk(input logic [31:0] pc, input logic [4:0] rs1, input logic [4:0] rs2,
                                input logic [4:0] rd, input logic [63:0] imm, input logic [2:0] fmt,
                                input logic u1, input logic u2, input logic wr, input logic ill);
        exp_t e;
        e = '{pc, rs1, rs2, rd, imm, fmt, u1, u2, wr, ill};
        return e;
    endfunction

    // addi x<k>, x0, k : rs2 field equals k, imm equals k, nop when k = 0
    function automatic logic [31:0] addi_enc(input int k);
        return {12'(k), 5'd0, 3'b000, 5'(k), 7'b0010011};
    endfunction

    function automatic exp_t addi_exp(input int k, input logic [31:0] pc);
        return mk(pc, 5'd0, 5'(k), 5'(k), 64'(k), 3'd1, 1'b1, 1'b0, (k != 0), 1'b0);
    endfunction

    task automatic cmp(input string who, input exp_t e, input logic [31:0] pc, input logic [4:0] rs1,
                       input logic [4:0] rs2, input logic [4:0] rd, input logic [63:0] imm,
                       input logic [2:0] fmt, input logic u1, input logic u2, input logic wr,
                       input logic ill);
        check({who, "_pc"}, 64'(pc), 64'(e.pc));
        check({who, "_rs1"}, 64'(rs1), 64'(e.rs1));
        check({who, "_rs2"}, 64'(rs2), 64'(e.rs2));
        check({who, "_rd"}, 64'(rd), 64'(e.rd));
        check({who, "_imm"}, imm, e.imm);
        check({who, "_fmt"}, 64'(fmt), 64'(e.fmt));
        check({who, "_uses_rs1"}, 64'(u1), 64'(e.u1));
        check({who, "_uses_rs2"}, 64'(u2), 64'(e.u2));
        check({who, "_writes_rd"}, 64'(wr), 64'(e.wr));
        check({who, "_illegal"}, 64'(ill), 64'(e.ill));
    endtask

    // Scoreboard pop for the XLEN=32 instance on each transfer seen mid-cycle.
    always @(negedge clk) begin
        if (rst_n && b32.out_valid && b32.out_ready) begin
            checks++;
            assert (sb32.size() != 0) else begin
                failures++;
                $error("FAIL sb32_unexpected observed=pc_%0h expected=no_output", b32.out_pc);
            end
            if (sb32.size() != 0) begin
                e32 = sb32.pop_front();
                cmp("d32", e32, b32.out_pc, b32.out_rs1, b32.out_rs2, b32.out_rd, 64'(b32.out_imm),
                    b32.out_fmt, b32.out_uses_rs1, b32.out_uses_rs2, b32.out_writes_rd, b32.out_illegal);
            end
        end
    end

    // Scoreboard pop for the XLEN=64 instance.
    always @(negedge clk) begin
        if (rst_n && b64.out_valid && b64.out_ready) begin
            checks++;
            assert (sb64.size() != 0) else begin
                failures++;
                $error("FAIL sb64_unexpected observed=pc_%0h expected=no_output", b64.out_pc);
            end
            if (sb64.size() != 0) begin
                e64 = sb64.pop_front();
                cmp("d64", e64, b64.out_pc, b64.out_rs1, b64.out_rs2, b64.out_rd, b64.out_imm,
                    b64.out_fmt, b64.out_uses_rs1, b64.out_uses_rs2, b64.out_writes_rd, b64.out_illegal);
            end
        end
    end

    task automatic push32(input logic [31:0] instr, input logic [31:0] pc, input exp_t e, output bit acc);
        b32.in_valid = 1'b1;
        b32.in_instr = instr;
        b32.in_pc    = pc;
        acc = b32.in_ready;
        if (acc) sb32.push_back(e);
        @(posedge clk);
        #1;
        b32.in_valid = 1'b0;
    endtask

    task automatic push64(input logic [31:0] instr, input logic [31:0] pc, input exp_t e);
        b64.in_valid = 1'b1;
        b64.in_instr = instr;
        b64.in_pc    = pc;
        if (b64.in_ready) sb64.push_back(e);
        @(posedge clk);
        #1;
        b64.in_valid = 1'b0;
    endtask

    task automatic drain(input int budget);
        int n;
        n = 0;
        while ((sb32.size() != 0 || sb64.size() != 0) && n < budget) begin
            @(posedge clk);
            #1;
            n++;
        end
        @(posedge clk);
        #1;
        checks++;
        assert (sb32.size() == 0 && sb64.size() == 0) else begin
            failures++;
            $error("FAIL drain observed=%0d/%0d_pending expected=0", sb32.size(), sb64.size());
        end
    endtask

    initial begin
        bit acc;
        int accepted;
        checks = 0;
        failures = 0;
        rst_n = 1'b0;
        flush32 = 1'b0;
        flush64 = 1'b0;
        b32.in_valid = 1'b0; b32.in_instr = 32'd0; b32.in_pc = 32'd0; b32.out_ready = 1'b0;
        b64.in_valid = 1'b0; b64.in_instr = 32'd0; b64.in_pc = 32'd0; b64.out_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_out_valid", 64'(b32.out_valid), 64'd0);
        check("rst_out_pc", 64'(b32.out_pc), 64'd0);
        check("rst_out_imm", 64'(b32.out_imm), 64'd0);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        check("rst_in_ready", 64'(b32.in_ready), 64'd1);

        // addi x1,x0,-1 : two-cycle latency
        b32.out_ready = 1'b1;
        push32(32'hFFF00093, 32'h100,
               mk(32'h100, 5'd0, 5'd31, 5'd1, 64'hFFFF_FFFF, 3'd1, 1'b1, 1'b0, 1'b1, 1'b0), acc);
        check("lat_edge_n", 64'(b32.out_valid), 64'd0);
        @(posedge clk);
        #1;
        check("lat_edge_n1", 64'(b32.out_valid), 64'd1);
        check("lat_pc", 64'(b32.out_pc), 64'h100);
        drain(10);

        // srai, beq, bad slli encoding, add
        push32(32'h4071D113, 32'h104, mk(32'h104, 5'd3, 5'd7, 5'd2, 64'd7, 3'd1, 1'b1, 1'b0, 1'b1, 1'b0), acc);
        push32(32'hFE208EE3, 32'h108,
               mk(32'h108, 5'd1, 5'd2, 5'd29, 64'hFFFF_FFFC, 3'd3, 1'b1, 1'b1, 1'b0, 1'b0), acc);
        push32(32'h40109093, 32'h10C, mk(32'h10C, 5'd1, 5'd1, 5'd1, 64'd0, 3'd0, 1'b0, 1'b0, 1'b0, 1'b1), acc);
        push32(32'h002081B3, 32'h110, mk(32'h110, 5'd1, 5'd2, 5'd3, 64'd0, 3'd0, 1'b1, 1'b1, 1'b1, 1'b0), acc);
        drain(20);

        // RV64: lui sign-extension and all-zero illegal word
        b64.out_ready = 1'b1;
        push64(32'h800002B7, 32'h400,
               mk(32'h400, 5'd0, 5'd0, 5'd5, 64'hFFFF_FFFF_8000_0000, 3'd4, 1'b0, 1'b0, 1'b1, 1'b0));
        push64(32'h00000000, 32'h404, mk(32'h404, 5'd0, 5'd0, 5'd0, 64'd0, 3'd0, 1'b0, 1'b0, 1'b0, 1'b1));
        drain(20);

        // Capacity under backpressure: DEPTH + 1 accepted
        b32.out_ready = 1'b0;
        accepted = 0;
        for (int k = 0; k < 8; k++) begin
            push32(addi_enc(k), 32'h200 + 32'(4 * k), addi_exp(k, 32'h200 + 32'(4 * k)), acc);
            accepted += int'(acc);
        end
        check("cap_accepted", 64'(accepted), 64'd5);
        check("cap_in_ready", 64'(b32.in_ready), 64'd0);
        check("hold_valid", 64'(b32.out_valid), 64'd1);
        check("hold_pc", 64'(b32.out_pc), 64'h200);
        b32.out_ready = 1'b1;
        for (int i = 0; i < 5; i++) begin
            check("thru_valid", 64'(b32.out_valid), 64'd1);
            @(posedge clk);
            #1;
        end
        check("thru_done", 64'(b32.out_valid), 64'd0);
        drain(10);

        // Flush with a simultaneous push
        b32.out_ready = 1'b0;
        for (int k = 10; k < 13; k++) begin
            push32(addi_enc(k), 32'h500 + 32'(4 * k), addi_exp(k, 32'h500 + 32'(4 * k)), acc);
        end
        b32.in_valid = 1'b1;
        b32.in_instr = addi_enc(13);
        b32.in_pc    = 32'h5FF;
        flush32 = 1'b1;
        sb32.delete();
        @(posedge clk);
        #1;
        flush32 = 1'b0;
        b32.in_valid = 1'b0;
        check("flush_valid", 64'(b32.out_valid), 64'd0);
        check("flush_in_ready", 64'(b32.in_ready), 64'd1);
        b32.out_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk);
            #1;
            check("flush_empty", 64'(b32.out_valid), 64'd0);
        end
        push32(addi_enc(14), 32'h600, addi_exp(14, 32'h600), acc);
        drain(10);

        // Asynchronous reset mid-stream
        b32.out_ready = 1'b0;
        for (int k = 20; k < 23; k++) begin
            push32(addi_enc(k), 32'h700 + 32'(4 * k), addi_exp(k, 32'h700 + 32'(4 * k)), acc);
        end
        #2;
        rst_n = 1'b0;
        #1;
        check("arst_valid", 64'(b32.out_valid), 64'd0);
        check("arst_pc", 64'(b32.out_pc), 64'd0);
        check("arst_imm", 64'(b32.out_imm), 64'd0);
        check("arst_rd", 64'(b32.out_rd), 64'd0);
        check("arst_fmt", 64'(b32.out_fmt), 64'd0);
        sb32.delete();
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        check("arst_in_ready", 64'(b32.in_ready), 64'd1);
        check("arst_valid_after", 64'(b32.out_valid), 64'd0);
        b32.out_ready = 1'b1;
        push32(addi_enc(5), 32'h800, addi_exp(5, 32'h800), acc);
        drain(10);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
